gcm_gctr_seq: RTL and testbench

GCM_GCTR_SEQ -- requirements
Module: gcm_gctr_seq

---
 rtl/gcm_gctr_seq.sv | 208 ++++++++++++++++++++
 tb/tb_gcm_gctr_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gcm_gctr_seq.sv
// gcm_gctr_seq: sequences one GCM job through an external GCTR/AES engine.
// For each job it asks the engine for H = E(K,0), then E(K,Y0), then pulls
// the data blocks from upstream one at a time and runs each through the
// engine. Every engine request is a RUN_x phase with a watchdog, followed by
// a GAP_x phase that waits for the level-type result valid to drop, so each
// request gets exactly one capture.
//
// Ports
//   iClk, iRstn                 clock, async active-low reset
//   iStart, iKey, iKeylen,      job request and parameters (sampled in IDLE)
//   iIV, iNumBlocks
//   iBlock, iBlock_valid,       upstream data block handshake
//   oBlock_ready
//   oGctr*                      engine request controls and data
//   iGctrResult(_valid)         engine result
//   oH, oEY0, oOut (+_valid)    captured results, valid pulses one cycle
//   oBusy, oDone, oError        job status
module gcm_gctr_seq #(
  parameter int NBLK_W  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              iClk,
  input  logic              iRstn,
  input  logic              iStart,
  input  logic [0:255]      iKey,
  input  logic              iKeylen,
  input  logic [0:95]       iIV,
  input  logic [NBLK_W-1:0] iNumBlocks,
  input  logic [0:127]      iBlock,
  input  logic              iBlock_valid,
  output logic              oBlock_ready,
  output logic              oGctrInit,
  output logic              oGctrHashKey,
  output logic              oGctrY0,
  output logic              oGctrKey_valid,
  output logic              oGctrIV_valid,
  output logic              oGctrBlock_valid,
  output logic [0:255]      oGctrKey,
  output logic              oGctrKeylen,
  output logic [0:95]       oGctrIV,
  output logic [0:127]      oGctrBlock,
  input  logic [0:127]      iGctrResult,
  input  logic              iGctrResult_valid,
  output logic [0:127]      oH,
  output logic [0:127]      oEY0,
  output logic [0:127]      oOut,
  output logic              oH_valid,
  output logic              oEY0_valid,
  output logic              oOut_valid,
  output logic              oBusy,
  output logic              oDone,
  output logic              oError
);

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, RUN_H, GAP_H, RUN_Y0, GAP_Y0, WAIT_BLK, RUN_D, GAP_D, DONE
  } state_t;

  state_t            state, state_nxt;
  logic [NBLK_W-1:0] count, issued;
  logic [WD_W-1:0]   wd;
  logic [0:127]      blk;

  logic run, start_job, accept, capture, timeout;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next state and per-cycle events
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    start_job = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (iStart) begin
          start_job = 1'b1;
          state_nxt = RUN_H;
        end
      end
      RUN_H, RUN_Y0, RUN_D: begin
        run = 1'b1;
        // a result arriving in the last watchdog cycle still wins
        if (iGctrResult_valid) begin
          capture = 1'b1;
          case (state)
            RUN_H:   state_nxt = GAP_H;
            RUN_Y0:  state_nxt = GAP_Y0;
            default: state_nxt = GAP_D;
          endcase
        end else if (wd == WD_LAST) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      GAP_H: begin
        if (!iGctrResult_valid) state_nxt = RUN_Y0;
      end
      GAP_Y0: begin
        if (!iGctrResult_valid)
          state_nxt = (count != '0) ? WAIT_BLK : DONE;
      end
      GAP_D: begin
        if (!iGctrResult_valid)
          state_nxt = (issued < count) ? WAIT_BLK : DONE;
      end
      WAIT_BLK: begin
        if (iBlock_valid) begin
          accept    = 1'b1;
          state_nxt = RUN_D;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: job parameters, counters, captured results
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      oGctrKey    <= '0;
      oGctrKeylen <= 1'b0;
      oGctrIV     <= '0;
      blk         <= '0;
      count       <= '0;
      issued      <= '0;
      wd          <= '0;
      oH          <= '0;
      oEY0        <= '0;
      oOut        <= '0;
      oH_valid    <= 1'b0;
      oEY0_valid  <= 1'b0;
      oOut_valid  <= 1'b0;
      oError      <= 1'b0;
    end else begin
      oH_valid   <= 1'b0;
      oEY0_valid <= 1'b0;
      oOut_valid <= 1'b0;
      oError     <= timeout;

      if (start_job) begin
        oGctrKey    <= iKey;
        oGctrKeylen <= iKeylen;
        oGctrIV     <= iIV;
        count       <= iNumBlocks;
        issued      <= '0;
        blk         <= '0;   // H and Y0 requests carry a zero block
      end

      // issued only advances while below count, so it cannot wrap
      if (accept) begin
        blk    <= iBlock;
        issued <= issued + NBLK_W'(1);
      end

      // watchdog is zero outside RUN_x, so each RUN_x entry starts at 0
      if (run && !capture && !timeout) wd <= wd + WD_W'(1);
      else                             wd <= '0;

      if (capture) begin
        case (state)
          RUN_H: begin
            oH       <= iGctrResult;
            oH_valid <= 1'b1;
          end
          RUN_Y0: begin
            oEY0       <= iGctrResult;
            oEY0_valid <= 1'b1;
          end
          default: begin
            oOut       <= iGctrResult;
            oOut_valid <= 1'b1;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State-decoded outputs
  // ---------------------------------------------------------------------------
  assign oGctrInit        = run;
  assign oGctrKey_valid   = run;
  assign oGctrIV_valid    = run;
  assign oGctrBlock_valid = run;
  assign oGctrHashKey     = (state == RUN_H);
  assign oGctrY0          = (state == RUN_Y0);
  assign oGctrBlock       = blk;
  assign oBlock_ready     = (state == WAIT_BLK);
  assign oBusy            = (state != IDLE);
  assign oDone            = (state == DONE);

endmodule

// File: tb/tb_gcm_gctr_seq.sv
// Bench for gcm_gctr_seq: a behavioural engine answers each request after a
// programmable latency with a keyed function of the request; the expected
// H, E(K,Y0) and output blocks are computed from the job parameters and the
// blocks fed upstream.
module tb_gcm_gctr_seq;
  localparam int NBLK_W  = 4;
  localparam int TIMEOUT = 16;

  logic              iClk = 1'b0, iRstn = 1'b0, iStart = 1'b0;
  logic [0:255]      iKey = '0;
  logic              iKeylen = 1'b0;
  logic [0:95]       iIV = '0;
  logic [NBLK_W-1:0] iNumBlocks = '0;
  logic [0:127]      iBlock = '0;
  logic              iBlock_valid = 1'b0;
  logic [0:127]      iGctrResult = '0;
  logic              iGctrResult_valid = 1'b0;
  logic              oBlock_ready, oGctrInit, oGctrHashKey, oGctrY0;
  logic              oGctrKey_valid, oGctrIV_valid, oGctrBlock_valid, oGctrKeylen;
  logic [0:255]      oGctrKey;
  logic [0:95]       oGctrIV;
  logic [0:127]      oGctrBlock, oH, oEY0, oOut;
  logic              oH_valid, oEY0_valid, oOut_valid, oBusy, oDone, oError;

  gcm_gctr_seq #(.NBLK_W(NBLK_W), .TIMEOUT(TIMEOUT)) dut (
    .iClk(iClk), .iRstn(iRstn), .iStart(iStart), .iKey(iKey), .iKeylen(iKeylen),
    .iIV(iIV), .iNumBlocks(iNumBlocks), .iBlock(iBlock), .iBlock_valid(iBlock_valid),
    .oBlock_ready(oBlock_ready), .oGctrInit(oGctrInit), .oGctrHashKey(oGctrHashKey),
    .oGctrY0(oGctrY0), .oGctrKey_valid(oGctrKey_valid), .oGctrIV_valid(oGctrIV_valid),
    .oGctrBlock_valid(oGctrBlock_valid), .oGctrKey(oGctrKey), .oGctrKeylen(oGctrKeylen),
    .oGctrIV(oGctrIV), .oGctrBlock(oGctrBlock), .iGctrResult(iGctrResult),
    .iGctrResult_valid(iGctrResult_valid), .oH(oH), .oEY0(oEY0), .oOut(oOut),
    .oH_valid(oH_valid), .oEY0_valid(oEY0_valid), .oOut_valid(oOut_valid),
    .oBusy(oBusy), .oDone(oDone), .oError(oError)
  );

  always #5 iClk = ~iClk;

  // keyed stand-in for the block cipher; flags distinguish the request kind
  function automatic logic [0:127] eng_fn(input logic [0:255] k, input logic kl,
                                          input logic [0:95] iv, input logic [0:127] b,
                                          input logic hk, input logic y0);
    logic [0:127] r;
    r = k[0:127] ^ {iv, 30'd0, hk, y0} ^ {b[64:127], b[0:63]};
    if (kl) r = r ^ k[128:255];
    return r;
  endfunction

  // ---------------- engine model ----------------
  int eng_lat = 10, eng_hold = 1, eng_cnt = 0, hold_left = 0, n_results = 0;
  bit eng_on = 1'b1;
  always @(negedge iClk) begin
    if (!iRstn) begin
      iGctrResult_valid = 1'b0; eng_cnt = 0; hold_left = 0;
    end else if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) iGctrResult_valid = 1'b0;
    end else if (oGctrInit && eng_on) begin
      eng_cnt++;
      if (eng_cnt >= eng_lat) begin
        iGctrResult = eng_fn(oGctrKey, oGctrKeylen, oGctrIV, oGctrBlock, oGctrHashKey, oGctrY0);
        iGctrResult_valid = 1'b1;
        hold_left = eng_hold; eng_cnt = 0; n_results++;
      end
    end else eng_cnt = 0;
  end

  // ---------------- upstream block feeder ----------------
  logic [0:127] blk_mem[$];
  int fed = 0;
  bit stray = 1'b0;
  always @(negedge iClk) begin
    if (!iRstn) begin
      fed = blk_mem.size(); iBlock_valid = 1'b0;
    end else if (oBlock_ready && fed < blk_mem.size()) begin
      iBlock = blk_mem[fed]; fed++; iBlock_valid = 1'b1;
    end else if (stray) begin
      iBlock = {$urandom, $urandom, $urandom, $urandom}; iBlock_valid = 1'b1;
    end else iBlock_valid = 1'b0;
  end

  // ---------------- output monitor ----------------
  int cyc = 0, h_cnt = 0, ey_cnt = 0, done_cnt = 0, err_cnt = 0, err_cyc = 0;
  int rdy_cyc = 0, init_rise = 0, bad_blk = 0;
  logic prev_init = 1'b0;
  logic [0:127] out_q[$];
  always @(posedge iClk) cyc++;
  always @(negedge iClk) begin
    if (oH_valid) h_cnt++;
    if (oEY0_valid) ey_cnt++;
    if (oOut_valid) out_q.push_back(oOut);
    if (oDone) done_cnt++;
    if (oError) begin err_cnt++; err_cyc = cyc; end
    if (oBlock_ready) rdy_cyc++;
    if (oGctrInit && !prev_init) init_rise++;
    prev_init = oGctrInit;
    if (oGctrInit && (oGctrHashKey || oGctrY0) && oGctrBlock != '0) bad_blk++;
  end

  // ---------------- checking ----------------
  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [0:255] r_key;
  logic         r_kl;
  logic [0:95]  r_iv;
  int r_n, base_blk, base_out, s_h, s_ey, s_done, s_err, s_rdy, s_res, s_rise, t0;

  task automatic launch(input int n, input bit zero_kv);
    logic [0:127] b;
    r_kl = zero_kv ? 1'b0 : 1'($urandom);
    for (int i = 0; i < 8; i++) r_key[i*32 +: 32] = zero_kv ? 32'd0 : 32'($urandom);
    for (int i = 0; i < 3; i++) r_iv[i*32 +: 32]  = zero_kv ? 32'd0 : 32'($urandom);
    r_n = n;
    base_blk = blk_mem.size(); base_out = out_q.size();
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) b[j*32 +: 32] = 32'($urandom);
      blk_mem.push_back(b);
    end
    s_h = h_cnt; s_ey = ey_cnt; s_done = done_cnt; s_err = err_cnt;
    s_rdy = rdy_cyc; s_res = n_results; s_rise = init_rise;
    @(negedge iClk);
    iKey = r_key; iKeylen = r_kl; iIV = r_iv; iNumBlocks = NBLK_W'(n); iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0; t0 = cyc;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int k;
    k = 0;
    while (done_cnt == s_done && err_cnt == s_err && k < budget) begin
      @(negedge iClk); k++;
    end
    chk({tag, "_ends_in_budget"}, 256'(k < budget), 256'(1));
    repeat (2) @(negedge iClk);
  endtask

  task automatic check_job(input string tag);
    chk({tag, "_H"},    256'(oH),   256'(eng_fn(r_key, r_kl, r_iv, '0, 1'b1, 1'b0)));
    chk({tag, "_EY0"},  256'(oEY0), 256'(eng_fn(r_key, r_kl, r_iv, '0, 1'b0, 1'b1)));
    chk({tag, "_h_pulses"},   256'(h_cnt - s_h),   256'(1));
    chk({tag, "_ey0_pulses"}, 256'(ey_cnt - s_ey), 256'(1));
    chk({tag, "_out_pulses"}, 256'(out_q.size() - base_out), 256'(r_n));
    if (out_q.size() >= base_out + r_n)
      for (int i = 0; i < r_n; i++)
        chk({tag, "_out", $sformatf("%0d", i)}, 256'(out_q[base_out + i]),
            256'(eng_fn(r_key, r_kl, r_iv, blk_mem[base_blk + i], 1'b0, 1'b0)));
    chk({tag, "_done"},    256'(done_cnt - s_done), 256'(1));
    chk({tag, "_no_error"}, 256'(err_cnt - s_err),  256'(0));
    chk({tag, "_results"},  256'(n_results - s_res), 256'(r_n + 2));
    chk({tag, "_init_rises"}, 256'(init_rise - s_rise), 256'(r_n + 2));
    chk({tag, "_idle"}, 256'(oBusy), 256'(0));
  endtask

  initial begin
    int k;
    // reset state
    repeat (2) @(posedge iClk);
    #1;
    chk("rst_busy", 256'(oBusy), 256'(0));
    chk("rst_ready", 256'(oBlock_ready), 256'(0));
    chk("rst_init", 256'(oGctrInit), 256'(0));
    chk("rst_done_err", 256'({oDone, oError}), 256'(0));
    chk("rst_results", 256'({oH, oEY0}), 256'(0));
    chk("rst_out", 256'(oOut), 256'(0));
    chk("rst_key", 256'(oGctrKey), 256'(0));
    chk("rst_blk", 256'(oGctrBlock), 256'(0));
    // release mid-high so the very next rising edge takes iStart
    @(posedge iClk); #2 iRstn = 1'b1;

    // all-zero key/IV, two blocks
    launch(2, 1'b1);
    wait_end("zero2", 400);
    check_job("zero2");

    // random parameters, three blocks
    launch(3, 1'b0);
    wait_end("rnd3", 500);
    check_job("rnd3");

    // no data blocks
    launch(0, 1'b0);
    wait_end("cnt0", 200);
    check_job("cnt0");
    chk("cnt0_no_ready", 256'(rdy_cyc - s_rdy), 256'(0));

    // result valid held for 5 cycles
    eng_hold = 5;
    launch(1, 1'b0);
    wait_end("hold5", 400);
    check_job("hold5");
    eng_hold = 1;

    // iStart while busy and stray block valids are ignored
    stray = 1'b1;
    launch(2, 1'b0);
    repeat (20) @(negedge iClk);
    iKey = ~r_key; iNumBlocks = NBLK_W'(5); iStart = 1'b1;
    @(negedge iClk); iStart = 1'b0;
    wait_end("ignore", 500);
    stray = 1'b0;
    check_job("ignore");

    // maximum block count
    launch((1 << NBLK_W) - 1, 1'b0);
    wait_end("max", 3000);
    check_job("max");

    // silent engine: watchdog
    eng_on = 1'b0;
    launch(0, 1'b0);
    wait_end("tmo", 200);
    chk("tmo_error", 256'(err_cnt - s_err), 256'(1));
    chk("tmo_no_done", 256'(done_cnt - s_done), 256'(0));
    chk("tmo_latency", 256'(err_cyc - t0), 256'(TIMEOUT));
    chk("tmo_idle", 256'({oBusy, oGctrInit}), 256'(0));
    chk("tmo_no_h", 256'(h_cnt - s_h), 256'(0));
    eng_on = 1'b1;

    // asynchronous reset while a data block is in the engine
    launch(3, 1'b0);
    k = 0;
    while (!(oGctrInit && !oGctrHashKey && !oGctrY0) && k < 300) begin
      @(negedge iClk); k++;
    end
    chk("reach_run_d", 256'(k < 300), 256'(1));
    #2 iRstn = 1'b0;
    #1;
    chk("arst_busy_init", 256'({oBusy, oGctrInit, oBlock_ready}), 256'(0));
    chk("arst_results", 256'({oH, oEY0}), 256'(0));
    chk("arst_out", 256'(oOut), 256'(0));
    chk("arst_data", 256'({oGctrKey[0:127] ^ oGctrKey[128:255], oGctrBlock}), 256'(0));
    repeat (3) @(negedge iClk);
    @(posedge iClk); #2 iRstn = 1'b1;
    launch(2, 1'b0);
    wait_end("post_rst", 400);
    check_job("post_rst");

    chk("zero_block_in_h_y0", 256'(bad_blk), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
